// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
//
// Shares one SRAM controller between two requesting pipeline stages (p0, p1).
// One transaction is in flight at a time. Each transaction walks through
// IDLE (pick a winner and latch its request) -> BUSY (drive the controller
// until mem_ready) -> DONE (one-cycle ready pulse to the winner).
//
// Parameters
//   PRIORITY_MODE : 0 = round-robin between the ports,
//                   1 = fixed priority, with port 0 highest
//
// Ports
//   clk, rst                       : rising-edge clock, synchronous active-high reset
//   pN_wr_en / pN_rd_en            : write / read request from port N (both set = write)
//   pN_address / pN_write_data     : byte address and write word from port N
//   pN_read_data                   : registered read word, updated only by N's reads
//   pN_ready                       : one-cycle completion pulse for port N
//   pN_freeze                      : combinational stall for port N's stage
//   mem_wr_en / mem_rd_en          : request to the SRAM controller (BUSY only)
//   mem_address / mem_write_data   : latched request towards the controller
//   mem_read_data / mem_ready      : read word and completion pulse from the controller
// ---------------------------------------------------------------------------
module sram_arbiter #(
    parameter int PRIORITY_MODE = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_wr_en,
    input  logic        p1_wr_en,
    input  logic        p0_rd_en,
    input  logic        p1_rd_en,
    input  logic [31:0] p0_address,
    input  logic [31:0] p1_address,
    input  logic [31:0] p0_write_data,
    input  logic [31:0] p1_write_data,
    output logic [31:0] p0_read_data,
    output logic [31:0] p1_read_data,
    output logic        p0_ready,
    output logic        p1_ready,
    output logic        p0_freeze,
    output logic        p1_freeze,
    output logic        mem_wr_en,
    output logic        mem_rd_en,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    input  logic        mem_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic        grant;
    logic        last_grant;
    logic        op_write;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic        p0_req;
    logic        p1_req;
    logic        winner;
    logic        winner_write;

    assign p0_req = p0_wr_en | p0_rd_en;
    assign p1_req = p1_wr_en | p1_rd_en;

    // Winner selection for the IDLE edge. Under contention, round-robin hands
    // the slot to whichever port did not complete last; fixed mode always
    // favours port 0. A lone requester always wins.
    always_comb begin
        winner = 1'b0;
        if (p0_req && p1_req) begin
            if (PRIORITY_MODE == 1) begin
                winner = 1'b0;
            end else begin
                winner = ~last_grant;
            end
        end else if (p1_req) begin
            winner = 1'b1;
        end
    end

    // A port asserting both enables is treated as a write.
    assign winner_write = winner ? p1_wr_en : p0_wr_en;

    // The controller sees only latched values, so the requester may change
    // or withdraw its request while BUSY without disturbing the transaction.
    assign mem_address    = addr_q;
    assign mem_write_data = wdata_q;

    // Freeze follows the request, released only during the port's own DONE
    // so its stage can advance exactly when its ready pulses.
    assign p0_freeze = p0_req & ~((state == DONE) & ~grant);
    assign p1_freeze = p1_req & ~((state == DONE) &  grant);

    // Main FSM with registered controller enables and ready pulses. Reset
    // clears last_grant to 1 so port 0 wins the first round-robin contention,
    // and aborts any in-flight transaction without a ready pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            grant        <= 1'b0;
            last_grant   <= 1'b1;
            op_write     <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            p0_read_data <= 32'd0;
            p1_read_data <= 32'd0;
            p0_ready     <= 1'b0;
            p1_ready     <= 1'b0;
            mem_wr_en    <= 1'b0;
            mem_rd_en    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (p0_req || p1_req) begin
                        grant     <= winner;
                        op_write  <= winner_write;
                        addr_q    <= winner ? p1_address : p0_address;
                        wdata_q   <= winner ? p1_write_data : p0_write_data;
                        mem_wr_en <= winner_write;
                        mem_rd_en <= ~winner_write;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        if (!op_write) begin
                            if (grant) begin
                                p1_read_data <= mem_read_data;
                            end else begin
                                p0_read_data <= mem_read_data;
                            end
                        end
                        last_grant <= grant;
                        mem_wr_en  <= 1'b0;
                        mem_rd_en  <= 1'b0;
                        p0_ready   <= ~grant;
                        p1_ready   <= grant;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    p0_ready <= 1'b0;
                    p1_ready <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The block SHALL have parameter PRIORITY_MODE, default 0, with 0 = round-robin and 1 = fixed priority with port 0 highest.
REQ-002 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have ports p0_wr_en and p1_wr_en, input, 1 bit each: write request per requester.
REQ-005 The block SHALL have ports p0_rd_en and p1_rd_en, input, 1 bit each: read request per requester.
REQ-006 The block SHALL have ports p0_address and p1_address, input, 32 bits each: byte address.
REQ-007 The block SHALL have ports p0_write_data and p1_write_data, input, 32 bits each: write word.
REQ-008 The block SHALL have ports p0_read_data and p1_read_data, output, 32 bits each: registered read word.
REQ-009 The block SHALL have ports p0_ready and p1_ready, output, 1 bit each: one-cycle completion pulse.
REQ-010 The block SHALL have ports p0_freeze and p1_freeze, output, 1 bit each: stall for the requesting stage.
REQ-011 The block SHALL have ports mem_wr_en and mem_rd_en, output, 1 bit each: request to the SRAM controller.
REQ-012 The block SHALL have ports mem_address and mem_write_data, output, 32 bits each: to the SRAM controller.
REQ-013 The block SHALL have port mem_read_data, input, 32 bits: from the SRAM controller.
REQ-014 The block SHALL have port mem_ready, input, 1 bit: completion pulse from the SRAM controller.

Function
REQ-015 The FSM SHALL have states IDLE, BUSY and DONE, plus a 1-bit grant register and a 1-bit last-grant register.
REQ-016 A port SHALL be requesting when its wr_en or rd_en is 1.
REQ-017 In IDLE with any port requesting, the block SHALL select a winner at the clock edge, latch the winner's address, write_data and op (write if wr_en, else read), set grant, and enter BUSY.
REQ-018 In round-robin mode with both ports requesting, the winner SHALL be the port not equal to last-grant.
REQ-019 In fixed mode with both ports requesting, port 0 SHALL win.
REQ-020 With exactly one port requesting, that port SHALL win in either mode.
REQ-021 In BUSY, mem_address and mem_write_data SHALL equal the latched values, and exactly one of mem_wr_en or mem_rd_en SHALL be 1 per the latched op.
REQ-022 In IDLE and DONE, mem_wr_en and mem_rd_en SHALL both be 0.
REQ-023 While mem_wr_en and mem_rd_en are 0, mem_address and mem_write_data are don't-care.
REQ-024 BUSY SHALL hold until mem_ready = 1.
REQ-025 On the BUSY edge with mem_ready = 1, a read SHALL register mem_read_data into the granted port's read_data, and the block SHALL set last-grant to grant and enter DONE.
REQ-026 In DONE, the granted port's ready SHALL be 1 and the other port's ready SHALL be 0; the FSM SHALL return to IDLE at the next edge.
REQ-027 ready SHALL be 0 outside DONE.
REQ-028 pN_freeze SHALL be combinational: 1 when port N is requesting, except 0 in DONE when grant = N.
REQ-029 A port's read_data SHALL hold its value until that port's next completed read; writes SHALL NOT alter it.
REQ-030 If a port asserts wr_en and rd_en together, the block SHALL treat it as a write.
REQ-031 A request deasserted or changed while BUSY SHALL NOT affect the in-flight transaction, which completes with the latched values and still pulses ready.
REQ-032 A request of the losing port SHALL remain pending, with freeze = 1, and SHALL be arbitrated in the IDLE following DONE.
REQ-033 Minimum occupancy SHALL be IDLE + BUSY (n cycles) + DONE, giving ready exactly 1 cycle after mem_ready.
REQ-034 Back-to-back grants SHALL have one IDLE cycle between DONE and the next BUSY.

Reset
REQ-035 On rst = 1 at a clock edge, the block SHALL enter IDLE and clear grant to 0.
REQ-036 On rst = 1 at a clock edge, last-grant SHALL be set to 1, so port 0 wins the first round-robin contention.
REQ-037 On rst = 1 at a clock edge, p0_read_data and p1_read_data SHALL be cleared to 0.
REQ-038 After reset, ready, mem_wr_en and mem_rd_en SHALL be 0; freeze is then purely combinational per REQ-028.
REQ-039 Reset asserted in BUSY or DONE SHALL abort the transaction: no ready pulse and no read_data update.

Verification
REQ-040 Single read: p0 reads 0x100, mem_ready pulses 5 cycles after BUSY entry with data 0xDEADBEEF -> mem_rd_en=1 and mem_address=0x100 for those cycles; p0_read_data=0xDEADBEEF and p0_ready=1 the next cycle; p0_freeze=0 in DONE.
REQ-041 Contention round-robin: p0 and p1 both hold requests continuously after reset -> grants alternate p0, p1, p0, p1; each port is frozen until its own DONE.
REQ-042 Contention fixed (PRIORITY_MODE=1): same stimulus -> p0 is granted every time while held; p1 is granted only once p0 drops its request.
REQ-043 Write data integrity: p1 writes 0x12345678 to 0x40 and p0 then reads 0x40 -> mem_write_data=0x12345678 during p1's BUSY; p1_read_data is unchanged.
REQ-044 Withdrawn request: p0 read granted, then p0_rd_en drops in BUSY -> mem_rd_en stays 1 until mem_ready; p0_ready still pulses.
REQ-045 Reset mid-transaction: rst asserted in BUSY -> next cycle in IDLE with mem enables 0, no ready pulse, both read_data = 0.
